scmp_mem_arb: RTL and testbench
===============================

# scmp_mem_arb

Synchronous arbiter that shares the SC/MP demo board's on-chip byte RAM between the SC/MP CPU bus and a debug/loader port. It samples the CPU's RD_n/WR_n strobes in the clk_50m domain and detects their falling edges, then sequences single-port synchronous RAM accesses. CPU cycles always take priority, and debug accesses fill idle slots through a req/ack handshake. The block replaces strobe-edge-clocked memory writes and level-sensitive reads with fully synchronous logic.

## Interface
- ADDR_W, 5, RAM address width; CPU address is masked to the low ADDR_W bits.
- IDLE_DATA, 8'hFF, value driven on cpu_d_i while the CPU read strobe is deasserted.
- clk_50m  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  12  CPU address bus.
- cpu_d_o  in  8  CPU write data.
- cpu_rd_n  in  1  CPU read strobe, active-low, asynchronous to clk_50m edges.
- cpu_wr_n  in  1  CPU write strobe, active-low.
- cpu_d_i  out  8  read data returned to the CPU.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req is high.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  8  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  8  debug read data; valid in the dbg_ack cycle and held afterwards.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_we  out  1  RAM write enable, registered, one cycle wide.
- mem_wdata  out  8  RAM write data, registered.
- mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr.
- bus_err  out  1  sticky flag: RD and WR falling edges detected in the same cycle.

## Operation
- **Strobe sampling:** each of cpu_rd_n and cpu_wr_n passes through a 2-flop synchronizer. The synchronizer flops reset to 1.
- **Edge detection:** fall = previous synced value 1 and current synced value 0.
- **Pending flags:** each detected fall sets its own pending flag, rd_pend or wr_pend. The flag clears when the access is issued.
- **FSM states:** IDLE, CPU_RD, CPU_RD_WAIT, CPU_WR, DBG_RD, DBG_RD_WAIT, DBG_WR.
- **IDLE priority order:**
  1. wr_pend → CPU_WR.
  2. Otherwise rd_pend → CPU_RD.
  3. Otherwise dbg_req && dbg_we → DBG_WR.
  4. Otherwise dbg_req → DBG_RD.
- **CPU_WR:** mem_addr = cpu_addr masked to ADDR_W bits, mem_wdata = cpu_d_o, mem_we = 1. Next state IDLE.
- **CPU_RD:** mem_addr = masked cpu_addr. Next state CPU_RD_WAIT.
- **CPU_RD_WAIT:** load cpu_d_i from mem_rdata. Next state IDLE.
- **cpu_d_i hold:** cpu_d_i holds the loaded value while the synced rd_n is 0. It returns to IDLE_DATA in the cycle after the synced rd_n rises.
- **DBG_WR:** mem_we = 1 with dbg_addr/dbg_wdata; dbg_ack pulses in this state. Next state IDLE.
- **DBG_RD:** issues dbg_addr. DBG_RD_WAIT captures mem_rdata into dbg_rdata and pulses dbg_ack. Next state IDLE.
- **Debug re-arm:** a debug requester must drop dbg_req in the cycle after dbg_ack to avoid a repeat access. A new request is accepted no earlier than the cycle after the ack.
- **CPU edge during a debug access:** the edge is latched in its pending flag and served immediately after the debug access completes. A debug access is never aborted.
- **Simultaneous RD and WR falls:** only the write is serviced, the read edge is discarded, and bus_err sets. bus_err clears only on reset.
- **Address masking:** bits 11:ADDR_W of cpu_addr are ignored, so accesses alias (wrap) modulo 2^ADDR_W.
- **Reset mid-access:** all state returns to IDLE and all pending flags clear. No partial write is ever issued after reset deasserts.

## Timing
- **Reset values:** cpu_d_i = IDLE_DATA, dbg_ack = 0, dbg_rdata = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0, bus_err = 0, state = IDLE.
- **Edge-detect latency:** a fall is detected 2 cycles after the pin change (synchronizer delay).
- **CPU read, fall detected in cycle N with FSM idle:**
  - mem_addr valid in N+2.
  - mem_rdata valid in N+3.
  - cpu_d_i updated in N+4.
  - Pin-to-data is 6 cycles (120 ns), far shorter than the divided CPU clock period.
- **CPU write:** mem_we is high in cycle N+2 for exactly one cycle.
- **Worst case, CPU edge arriving during a debug read:** 2 extra cycles.
- **Debug read:** dbg_ack is 3 cycles after dbg_req is sampled high in IDLE.
- **Debug write:** dbg_ack is 2 cycles after dbg_req is sampled high in IDLE.
- **Throughput:** at most one RAM access in flight; no back-to-back overlap.

## Test plan
- **CPU read:** preload RAM[5]=8'hA7; drive cpu_addr=12'h025, pulse cpu_rd_n low for 40 cycles → cpu_d_i = 8'hA7 within 6 cycles of the fall, held while low, 8'hFF within 3 cycles of the rise.
- **CPU write:** drive cpu_addr=12'h01F, cpu_d_o=8'h3C, wr_n low → exactly one mem_we pulse with mem_addr=31, mem_wdata=8'h3C; a later read of address 31 returns 8'h3C.
- **Debug read vs CPU read:** dbg_req read of address 2 held high; cpu_rd_n falls 1 cycle after the debug access starts → debug completes with dbg_ack and correct dbg_rdata; the CPU read follows, with cpu_d_i valid within 8 cycles of its fall.
- **Debug fill-up:** debug writes of 8'h00..8'h1F to addresses 0..31 → each produces exactly one dbg_ack; CPU reads of every address return the written data.
- **Simultaneous strobes:** cpu_rd_n and cpu_wr_n fall in the same clk_50m cycle → one write only, no cpu_d_i load, bus_err = 1 and stays set until reset.
- **Reset mid-access:** assert rst_n low during CPU_WR state entry with a debug request pending → no mem_we after reset release, all outputs at reset values, dbg_ack = 0.

Source files
------------

// File: rtl/scmp_mem_arb_if.sv
// SC/MP RAM arbiter bus bundle: CPU strobes, debug port and RAM port.
// slave = arbiter side, master = environment (CPU, debugger, RAM).
interface scmp_mem_arb_if #(
    parameter int ADDR_W = 5
);
    logic [11:0]       cpu_addr;
    logic [7:0]        cpu_d_o;
    logic              cpu_rd_n;
    logic              cpu_wr_n;
    logic [7:0]        cpu_d_i;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        dbg_wdata;
    logic              dbg_ack;
    logic [7:0]        dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              bus_err;

    modport slave (
        input  cpu_addr, cpu_d_o, cpu_rd_n, cpu_wr_n,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_d_i, dbg_ack, dbg_rdata,
        output mem_addr, mem_we, mem_wdata, bus_err
    );

    modport master (
        output cpu_addr, cpu_d_o, cpu_rd_n, cpu_wr_n,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_d_i, dbg_ack, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata, bus_err
    );
endinterface

// File: rtl/scmp_mem_arb.sv
// Shares a single-port sync RAM between SC/MP CPU strobes and a debug port.
// CPU strobe falls are synchronized into clk_50m and always win over debug.
module scmp_mem_arb #(
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
    input logic            clk_50m,
    input logic            rst_n,
    scmp_mem_arb_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_RD,
        S_CPU_RD_WAIT,
        S_CPU_WR,
        S_DBG_RD,
        S_DBG_RD_WAIT,
        S_DBG_WR
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // [0] first flop, [1] synced value, [2] previous synced value
    logic [2:0]        r_rd_sync;
    logic [2:0]        r_wr_sync;
    logic              r_rd_pend;
    logic              r_wr_pend;
    logic              r_bus_err;
    logic [7:0]        r_cpu_d_i;
    logic              r_dbg_ack;
    logic [7:0]        r_dbg_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;

    logic              w_rd_fall;
    logic              w_wr_fall;
    logic              w_dbg_ok;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic [ADDR_W-1:0] w_cpu_addr;
    logic [ADDR_W-1:0] w_mem_addr_nx;
    logic              w_mem_we_nx;
    logic [7:0]        w_mem_wdata_nx;
    logic              w_addr_unused;

    assign w_rd_fall     = r_rd_sync[2] & ~r_rd_sync[1];
    assign w_wr_fall     = r_wr_sync[2] & ~r_wr_sync[1];
    assign w_cpu_addr    = io_bus.cpu_addr[ADDR_W-1:0];
    assign w_addr_unused = ^io_bus.cpu_addr[11:ADDR_W];
    // the ack cycle must not re-accept the request still being held high
    assign w_dbg_ok      = io_bus.dbg_req & ~r_dbg_ack;

    always_comb begin
        w_state_nx     = r_state;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_mem_we_nx    = 1'b0;
        w_rd_issue     = 1'b0;
        w_wr_issue     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_wr_pend) begin
                    w_state_nx     = S_CPU_WR;
                    w_mem_addr_nx  = w_cpu_addr;
                    w_mem_wdata_nx = io_bus.cpu_d_o;
                    w_mem_we_nx    = 1'b1;
                    w_wr_issue     = 1'b1;
                end else if (r_rd_pend) begin
                    w_state_nx    = S_CPU_RD;
                    w_mem_addr_nx = w_cpu_addr;
                    w_rd_issue    = 1'b1;
                end else if (w_dbg_ok && io_bus.dbg_we) begin
                    w_state_nx     = S_DBG_WR;
                    w_mem_addr_nx  = io_bus.dbg_addr;
                    w_mem_wdata_nx = io_bus.dbg_wdata;
                    w_mem_we_nx    = 1'b1;
                end else if (w_dbg_ok) begin
                    w_state_nx    = S_DBG_RD;
                    w_mem_addr_nx = io_bus.dbg_addr;
                end
            end
            S_CPU_RD: w_state_nx = S_CPU_RD_WAIT;
            S_DBG_RD: w_state_nx = S_DBG_RD_WAIT;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_sync   <= 3'b111;
            r_wr_sync   <= 3'b111;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cpu_d_i   <= IDLE_DATA;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= 8'h00;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_rd_sync   <= {r_rd_sync[1:0], io_bus.cpu_rd_n};
            r_wr_sync   <= {r_wr_sync[1:0], io_bus.cpu_wr_n};
            // a read edge coinciding with a write edge is dropped
            r_rd_pend   <= (w_rd_fall & ~w_wr_fall) | (r_rd_pend & ~w_rd_issue);
            r_wr_pend   <= w_wr_fall | (r_wr_pend & ~w_wr_issue);
            r_bus_err   <= r_bus_err | (w_rd_fall & w_wr_fall);
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_dbg_ack   <= (r_state == S_DBG_WR) || (r_state == S_DBG_RD_WAIT);
            if (r_state == S_DBG_RD_WAIT) begin
                r_dbg_rdata <= io_bus.mem_rdata;
            end
            if (r_state == S_CPU_RD_WAIT) begin
                r_cpu_d_i <= io_bus.mem_rdata;
            end else if (r_rd_sync[1]) begin
                r_cpu_d_i <= IDLE_DATA;
            end
        end
    end

    assign io_bus.cpu_d_i   = r_cpu_d_i;
    assign io_bus.dbg_ack   = r_dbg_ack;
    assign io_bus.dbg_rdata = r_dbg_rdata;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.bus_err   = r_bus_err;
endmodule

// File: tb/tb_scmp_mem_arb.sv
// Bench for scmp_mem_arb: sync RAM model, write/read scoreboards, and
// scenario tasks covering CPU, debug, collision and reset behaviour.
module tb_scmp_mem_arb;
    localparam int AW = 5;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;

    always #10 clk_50m = ~clk_50m;

    scmp_mem_arb_if #(.ADDR_W(AW)) ifc ();

    scmp_mem_arb #(
        .ADDR_W    (AW),
        .IDLE_DATA (8'hFF)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .io_bus  (ifc)
    );

    logic [7:0] ram [32];
    logic [7:0] exp_mem [32];
    wr_t        q_wr [$];
    logic [7:0] q_rd [$];
    logic [7:0] q_dbg [$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_we  = 0;
    int         n_ack = 0;

    always @(posedge clk_50m) begin
        if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
        ifc.mem_rdata <= ram[ifc.mem_addr];
    end

    // every RAM write must match the next expected write
    always @(negedge clk_50m) begin
        wr_t e;
        if (rst_n) begin
            if (ifc.dbg_ack) n_ack++;
            if (ifc.mem_we) begin
                n_we++;
                n_chk++;
                if (q_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_we: got addr=%0d data=%h, none expected",
                             ifc.mem_addr, ifc.mem_wdata);
                end else begin
                    e = q_wr.pop_front();
                    if ({ifc.mem_addr, ifc.mem_wdata} !== e) begin
                        n_err++;
                        $display("FAIL mem_write: got addr=%0d data=%h, want addr=%0d data=%h",
                                 ifc.mem_addr, ifc.mem_wdata, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [7:0] d);
        int lat;
        int a0;
        bit seen;
        q_wr.push_back({a, d});
        exp_mem[a] = d;
        a0 = n_ack;
        seen = 0;
        lat = -1;
        ifc.dbg_addr = a;
        ifc.dbg_wdata = d;
        ifc.dbg_we = 1'b1;
        ifc.dbg_req = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk_50m);
            if (ifc.dbg_ack) begin
                seen = 1;
                lat = i;
            end
        end
        step();
        ifc.dbg_req = 1'b0;
        step();
        step();
        n_chk++;
        if (!seen || lat != 2) begin
            n_err++;
            $display("FAIL dbg_wr_lat: addr=%0d got %0d cycles, want 2", a, lat);
        end
        n_chk++;
        if (n_ack - a0 != 1) begin
            n_err++;
            $display("FAIL dbg_wr_acks: addr=%0d got %0d acks, want 1", a, n_ack - a0);
        end
    endtask

    task automatic dbg_read(input logic [4:0] a);
        int lat;
        int a0;
        bit seen;
        logic [7:0] e;
        q_dbg.push_back(exp_mem[a]);
        a0 = n_ack;
        seen = 0;
        lat = -1;
        e = 8'h00;
        ifc.dbg_addr = a;
        ifc.dbg_we = 1'b0;
        ifc.dbg_req = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk_50m);
            if (ifc.dbg_ack) begin
                seen = 1;
                lat = i;
                e = q_dbg.pop_front();
                n_chk++;
                if (ifc.dbg_rdata !== e) begin
                    n_err++;
                    $display("FAIL dbg_rd_data: addr=%0d got %h, want %h", a, ifc.dbg_rdata, e);
                end
            end
        end
        step();
        ifc.dbg_req = 1'b0;
        step();
        step();
        n_chk++;
        if (!seen || lat != 3) begin
            n_err++;
            $display("FAIL dbg_rd_lat: addr=%0d got %0d cycles, want 3", a, lat);
        end
        n_chk++;
        if (ifc.dbg_rdata !== e || n_ack - a0 != 1) begin
            n_err++;
            $display("FAIL dbg_rd_hold: got %h acks=%0d, want %h acks=1",
                     ifc.dbg_rdata, n_ack - a0, e);
        end
    endtask

    task automatic cpu_read(input logic [11:0] addr, input int hold, input int maxlat,
                            input bit exact);
        int lat;
        bit got;
        logic [7:0] e;
        q_rd.push_back(exp_mem[addr[4:0]]);
        got = 0;
        lat = -1;
        ifc.cpu_addr = addr;
        ifc.cpu_rd_n = 1'b0;
        for (int i = 0; i <= maxlat && !got; i++) begin
            @(negedge clk_50m);
            if (ifc.cpu_d_i !== 8'hFF) begin
                got = 1;
                lat = i;
            end
        end
        e = q_rd.pop_front();
        n_chk++;
        if (!got || ifc.cpu_d_i !== e) begin
            n_err++;
            $display("FAIL cpu_rd_data: addr=%h got %h lat=%0d, want %h", addr, ifc.cpu_d_i, lat, e);
        end
        if (exact) begin
            n_chk++;
            if (lat != 6) begin
                n_err++;
                $display("FAIL cpu_rd_lat: addr=%h got %0d cycles, want 6", addr, lat);
            end
        end
        repeat (hold) step();
        @(negedge clk_50m);
        n_chk++;
        if (ifc.cpu_d_i !== e) begin
            n_err++;
            $display("FAIL cpu_rd_hold: addr=%h got %h, want %h", addr, ifc.cpu_d_i, e);
        end
        step();
        ifc.cpu_rd_n = 1'b1;
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        if (exact) begin
            n_chk++;
            if (ifc.cpu_d_i !== e) begin
                n_err++;
                $display("FAIL cpu_rd_release_early: got %h, want %h", ifc.cpu_d_i, e);
            end
        end
        @(posedge clk_50m);
        @(negedge clk_50m);
        n_chk++;
        if (ifc.cpu_d_i !== 8'hFF) begin
            n_err++;
            $display("FAIL cpu_rd_idle: got %h, want ff", ifc.cpu_d_i);
        end
        step();
        step();
    endtask

    task automatic cpu_write(input logic [11:0] addr, input logic [7:0] d);
        int lat;
        int w0;
        q_wr.push_back({addr[4:0], d});
        exp_mem[addr[4:0]] = d;
        w0 = n_we;
        lat = -1;
        ifc.cpu_addr = addr;
        ifc.cpu_d_o = d;
        ifc.cpu_wr_n = 1'b0;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk_50m);
            if (ifc.mem_we) lat = i;
        end
        repeat (8) step();
        ifc.cpu_wr_n = 1'b1;
        repeat (5) step();
        n_chk++;
        if (lat != 4) begin
            n_err++;
            $display("FAIL cpu_wr_lat: got %0d cycles, want 4", lat);
        end
        n_chk++;
        if (n_we - w0 != 1) begin
            n_err++;
            $display("FAIL cpu_wr_count: got %0d pulses, want 1", n_we - w0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk_50m);
        n_chk++;
        if (ifc.cpu_d_i !== 8'hFF) begin
            n_err++;
            $display("FAIL rst_cpu_d_i: got %h, want ff", ifc.cpu_d_i);
        end
        n_chk++;
        if (ifc.dbg_ack !== 1'b0 || ifc.dbg_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL rst_dbg: got ack=%b rdata=%h, want 0 00", ifc.dbg_ack, ifc.dbg_rdata);
        end
        n_chk++;
        if (ifc.mem_addr !== 5'd0 || ifc.mem_we !== 1'b0 || ifc.mem_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mem: got addr=%0d we=%b wdata=%h, want 0 0 00",
                     ifc.mem_addr, ifc.mem_we, ifc.mem_wdata);
        end
        n_chk++;
        if (ifc.bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_bus_err: got %b, want 0", ifc.bus_err);
        end
        step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_dbg_fill();
        for (int i = 0; i < 32; i++) dbg_write(i[4:0], i[7:0]);
        for (int i = 0; i < 32; i++) begin
            cpu_read({7'($urandom), i[4:0]}, 2, 8, 1'b1);
        end
    endtask

    task automatic test_cpu_read();
        dbg_write(5'd5, 8'hA7);
        cpu_read(12'h025, 33, 6, 1'b1);
    endtask

    task automatic test_cpu_write();
        cpu_write(12'h01F, 8'h3C);
        dbg_read(5'd31);
        cpu_read(12'hC1F, 3, 6, 1'b1);
    endtask

    task automatic test_dbg_vs_cpu();
        logic [7:0] ed;
        logic [7:0] ec;
        int ack_at;
        int cpu_at;
        int acks;
        q_dbg.push_back(exp_mem[2]);
        q_rd.push_back(exp_mem[9]);
        ifc.dbg_addr = 5'd2;
        ifc.dbg_we = 1'b0;
        ifc.dbg_req = 1'b1;
        step();
        step();
        ifc.cpu_addr = 12'h109;
        ifc.cpu_rd_n = 1'b0;
        ack_at = -1;
        cpu_at = -1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50m);
            if (ifc.dbg_ack) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = i;
                    ed = q_dbg.pop_front();
                    n_chk++;
                    if (ifc.dbg_rdata !== ed) begin
                        n_err++;
                        $display("FAIL mix_dbg_data: got %h, want %h", ifc.dbg_rdata, ed);
                    end
                end
            end
            if (cpu_at < 0 && ifc.cpu_d_i !== 8'hFF) begin
                cpu_at = i;
                ec = q_rd.pop_front();
                n_chk++;
                if (ifc.cpu_d_i !== ec) begin
                    n_err++;
                    $display("FAIL mix_cpu_data: got %h, want %h", ifc.cpu_d_i, ec);
                end
            end
            step();
            if (ack_at >= 0) ifc.dbg_req = 1'b0;
        end
        n_chk++;
        if (ack_at < 0 || acks != 1) begin
            n_err++;
            $display("FAIL mix_dbg_ack: got %0d acks, want 1", acks);
        end
        n_chk++;
        if (cpu_at < 0 || cpu_at > 8 || cpu_at < ack_at) begin
            n_err++;
            $display("FAIL mix_cpu_lat: got cpu=%0d ack=%0d, want ack<=cpu<=8", cpu_at, ack_at);
        end
        ifc.cpu_rd_n = 1'b1;
        ifc.dbg_req = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_simul_strobe();
        int w0;
        q_wr.push_back({5'd4, 8'h5A});
        exp_mem[4] = 8'h5A;
        w0 = n_we;
        ifc.cpu_addr = 12'h0E4;
        ifc.cpu_d_o = 8'h5A;
        ifc.cpu_rd_n = 1'b0;
        ifc.cpu_wr_n = 1'b0;
        repeat (12) step();
        @(negedge clk_50m);
        n_chk++;
        if (n_we - w0 != 1) begin
            n_err++;
            $display("FAIL sim_we_count: got %0d, want 1", n_we - w0);
        end
        n_chk++;
        if (ifc.cpu_d_i !== 8'hFF) begin
            n_err++;
            $display("FAIL sim_no_load: got %h, want ff", ifc.cpu_d_i);
        end
        n_chk++;
        if (ifc.bus_err !== 1'b1) begin
            n_err++;
            $display("FAIL sim_bus_err: got %b, want 1", ifc.bus_err);
        end
        step();
        ifc.cpu_rd_n = 1'b1;
        ifc.cpu_wr_n = 1'b1;
        repeat (4) step();
        dbg_read(5'd4);
        n_chk++;
        if (ifc.bus_err !== 1'b1) begin
            n_err++;
            $display("FAIL sim_bus_err_sticky: got %b, want 1", ifc.bus_err);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        int a0;
        ifc.cpu_addr = 12'h007;
        ifc.cpu_d_o = 8'h77;
        ifc.cpu_wr_n = 1'b0;
        repeat (3) step();
        ifc.dbg_addr = 5'd7;
        ifc.dbg_wdata = 8'h99;
        ifc.dbg_we = 1'b1;
        ifc.dbg_req = 1'b1;
        step();
        n_chk++;
        if (ifc.mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL mid_cpu_wr_entry: got mem_we=%b, want 1", ifc.mem_we);
        end
        rst_n = 1'b0;
        ifc.cpu_wr_n = 1'b1;
        ifc.dbg_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        w0 = n_we;
        a0 = n_ack;
        @(negedge clk_50m);
        n_chk++;
        if ({ifc.cpu_d_i, ifc.dbg_ack, ifc.dbg_rdata, ifc.mem_addr, ifc.mem_we,
             ifc.mem_wdata, ifc.bus_err} !== {8'hFF, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL mid_rst_vals: got d_i=%h ack=%b rd=%h a=%0d we=%b wd=%h err=%b, want ff 0 00 0 0 00 0",
                     ifc.cpu_d_i, ifc.dbg_ack, ifc.dbg_rdata, ifc.mem_addr, ifc.mem_we,
                     ifc.mem_wdata, ifc.bus_err);
        end
        repeat (15) step();
        n_chk++;
        if (n_we != w0 || n_ack != a0 || ifc.dbg_ack !== 1'b0) begin
            n_err++;
            $display("FAIL mid_quiet: got we=%0d acks=%0d, want 0 0", n_we - w0, n_ack - a0);
        end
        dbg_read(5'd7);
    endtask

    initial begin
        ifc.cpu_addr = 12'h000;
        ifc.cpu_d_o = 8'h00;
        ifc.cpu_rd_n = 1'b1;
        ifc.cpu_wr_n = 1'b1;
        ifc.dbg_req = 1'b0;
        ifc.dbg_we = 1'b0;
        ifc.dbg_addr = 5'd0;
        ifc.dbg_wdata = 8'h00;
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
        test_reset();
        test_dbg_fill();
        test_cpu_read();
        test_cpu_write();
        test_dbg_vs_cpu();
        test_simul_strobe();
        test_reset_mid();
        n_chk++;
        if (q_wr.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes: got %0d outstanding, want 0", q_wr.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
